// File: rtl/fe_fetch_redirect.sv
// fe_fetch_redirect
//
// Fetch-stage PC sequencer and instruction buffer. Issues one instruction
// memory read per cycle when there is room downstream, absorbs decode
// back-pressure with a one-entry skid buffer, and squashes wrong-path
// fetches when execute signals a taken branch or jump.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   redirect_valid  : taken branch / jump from execute this cycle
//   redirect_pc     : redirect target (low two bits forced to zero)
//   stall           : decode cannot accept a new fetch-latch value
//   imem_addr       : instruction memory read address (combinational)
//   imem_rdata      : read data, returned one cycle after the address
//   fe_valid        : fetch latch holds a valid instruction
//   fe_inst         : fetched instruction
//   fe_pc           : PC of fe_inst
//   fe_pcplus       : fe_pc + 4
//   fe_inst_count   : sequence number of fe_inst, 1 for the first after reset
module fe_fetch_redirect #(
    parameter int              DBITS    = 32,
    parameter int              INSTBITS = 32,
    parameter logic [DBITS-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect_valid,
    input  logic [DBITS-1:0]    redirect_pc,
    input  logic                stall,
    output logic [DBITS-1:0]    imem_addr,
    input  logic [INSTBITS-1:0] imem_rdata,
    output logic                fe_valid,
    output logic [INSTBITS-1:0] fe_inst,
    output logic [DBITS-1:0]    fe_pc,
    output logic [DBITS-1:0]    fe_pcplus,
    output logic [DBITS-1:0]    fe_inst_count
);

    localparam logic [DBITS-1:0] WORD_MASK = {{(DBITS-2){1'b1}}, 2'b00};
    localparam logic [DBITS-1:0] PC_STEP   = DBITS'(4);
    localparam logic [DBITS-1:0] CNT_STEP  = DBITS'(1);

    logic [DBITS-1:0]    pc_q;
    logic                req_v_q;
    logic [DBITS-1:0]    req_pc_q;
    logic                skid_v_q;
    logic [INSTBITS-1:0] skid_inst_q;
    logic [DBITS-1:0]    skid_pc_q;
    logic [DBITS-1:0]    cnt_q;

    logic [DBITS-1:0]    redirect_tgt;
    logic                adv;
    logic                latch_from_skid;
    logic                latch_from_arr;
    logic                skid_load;
    logic                skid_v_next;
    logic                issue;

    // Word-align the target by masking so every bit of the port is consumed.
    assign redirect_tgt = redirect_pc & WORD_MASK;

    always_comb begin
        adv             = !stall || !fe_valid;
        // The skid always has priority so instructions leave in order.
        latch_from_skid = adv && skid_v_q;
        latch_from_arr  = adv && !skid_v_q && req_v_q;
        // An arrival the latch does not take parks in the skid.
        skid_load       = req_v_q && (!adv || skid_v_q);
        if (skid_load)
            skid_v_next = 1'b1;
        else if (adv)
            skid_v_next = 1'b0;
        else
            skid_v_next = skid_v_q;
        // Only fetch when the skid will be free to catch the returning data.
        issue = !skid_v_next;

        if (reset)
            imem_addr = RESET_PC;
        else if (redirect_valid)
            imem_addr = redirect_tgt;
        else
            imem_addr = pc_q;
    end

    // ---- Control and fetch-latch stage ----
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            req_v_q  <= 1'b0;
            skid_v_q <= 1'b0;
            fe_valid <= 1'b0;
            fe_inst  <= '0;
            fe_pc    <= '0;
            cnt_q    <= '0;
        end else if (redirect_valid) begin
            // Redirect beats stall: the latch and skid hold wrong-path work.
            pc_q     <= redirect_tgt + PC_STEP;
            req_v_q  <= 1'b1;
            skid_v_q <= 1'b0;
            fe_valid <= 1'b0;
        end else begin
            req_v_q  <= issue;
            skid_v_q <= skid_v_next;
            if (issue)
                pc_q <= pc_q + PC_STEP;
            if (adv) begin
                fe_valid <= latch_from_skid || latch_from_arr;
                if (latch_from_skid) begin
                    fe_inst <= skid_inst_q;
                    fe_pc   <= skid_pc_q;
                    cnt_q   <= cnt_q + CNT_STEP;
                end else if (latch_from_arr) begin
                    fe_inst <= imem_rdata;
                    fe_pc   <= req_pc_q;
                    cnt_q   <= cnt_q + CNT_STEP;
                end
            end
        end
    end

    // ---- Request and skid data stage ----
    always_ff @(posedge clk) begin
        if (redirect_valid)
            req_pc_q <= redirect_tgt;
        else if (issue)
            req_pc_q <= pc_q;
        if (skid_load) begin
            skid_inst_q <= imem_rdata;
            skid_pc_q   <= req_pc_q;
        end
    end

    assign fe_pcplus     = fe_pc + PC_STEP;
    assign fe_inst_count = cnt_q;

endmodule

// File: tb/tb_fe_fetch_redirect.sv
module tb_fe_fetch_redirect;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        fe_valid;
    logic [31:0] fe_inst;
    logic [31:0] fe_pc;
    logic [31:0] fe_pcplus;
    logic [31:0] fe_inst_count;

    int checks   = 0;
    int failures = 0;
    int ovf_cnt  = 0;

    localparam logic [31:0] XKEY = 32'hA5A5_0000;

    fe_fetch_redirect #(
        .DBITS   (32),
        .INSTBITS(32),
        .RESET_PC(32'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .fe_valid      (fe_valid),
        .fe_inst       (fe_inst),
        .fe_pc         (fe_pc),
        .fe_pcplus     (fe_pcplus),
        .fe_inst_count (fe_inst_count)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data is the address with a fixed pattern.
    always @(posedge clk) imem_rdata <= imem_addr ^ XKEY;

    // An arrival that the latch cannot take while the skid is already full.
    always @(posedge clk)
        if (!reset && !redirect_valid && dut.req_v_q && dut.skid_v_q && fe_valid && stall)
            ovf_cnt <= ovf_cnt + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_addr(input string tag, input logic [31:0] exp);
        #1;
        check(tag, imem_addr, exp);
    endtask

    task automatic check_fe(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] cnt);
        check({tag, "_valid"}, {31'b0, fe_valid}, {31'b0, v});
        check({tag, "_count"}, fe_inst_count, cnt);
        if (v) begin
            check({tag, "_pc"}, fe_pc, pc);
            check({tag, "_inst"}, fe_inst, pc ^ XKEY);
            check({tag, "_pcplus"}, fe_pcplus, pc + 32'd4);
        end
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall          = 1'b0;
        repeat (3) tick();

        // Reset state
        check_fe("rst", 1'b0, 32'h0, 32'd0);
        check("rst_pc", fe_pc, 32'h0);
        check("rst_inst", fe_inst, 32'h0);
        check("rst_pcplus", fe_pcplus, 32'h4);
        check_addr("rst_addr", 32'h0);

        // Cycle 0: first issue
        reset = 1'b0;
        check_addr("c0_addr", 32'h0);
        tick();  // cycle 1
        check_fe("c1", 1'b0, 32'h0, 32'd0);
        check_addr("c1_addr", 32'h4);
        tick();  // cycle 2
        check_fe("c2", 1'b1, 32'h0, 32'd1);
        tick();  // cycle 3
        check_fe("c3", 1'b1, 32'h4, 32'd2);
        tick();  // cycle 4: stall for three cycles
        check_fe("c4", 1'b1, 32'h8, 32'd3);
        stall = 1'b1;
        check_addr("c4_addr", 32'h10);
        for (int i = 5; i <= 6; i++) begin
            tick();
            check_fe($sformatf("c%0d_stall", i), 1'b1, 32'h8, 32'd3);
            check_addr($sformatf("c%0d_addr", i), 32'h10);
        end
        tick();  // cycle 7: release
        stall = 1'b0;
        check_fe("c7", 1'b1, 32'h8, 32'd3);
        check_addr("c7_addr", 32'h10);
        tick();
        check_fe("c8", 1'b1, 32'hC, 32'd4);
        tick();
        check_fe("c9", 1'b1, 32'h10, 32'd5);
        tick();  // cycle 10: redirect to 0x100
        check_fe("c10", 1'b1, 32'h14, 32'd6);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        check_addr("rd1_addr", 32'h100);
        tick();
        redirect_valid = 1'b0;
        check_fe("rd1_n1", 1'b0, 32'h0, 32'd6);
        tick();
        check_fe("rd1_n2", 1'b1, 32'h100, 32'd7);
        tick();  // unaligned redirect target
        check_fe("rd1_n3", 1'b1, 32'h104, 32'd8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        check_addr("rd2_addr", 32'h100);
        tick();
        redirect_valid = 1'b0;
        check_fe("rd2_n1", 1'b0, 32'h0, 32'd8);
        tick();  // fill the skid with a stall
        check_fe("rd2_n2", 1'b1, 32'h100, 32'd9);
        stall = 1'b1;
        tick();  // skid full, redirect under stall
        check_fe("sk_full", 1'b1, 32'h100, 32'd9);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        check_addr("rd3_addr", 32'h40);
        tick();
        redirect_valid = 1'b0;
        check_fe("rd3_n1", 1'b0, 32'h0, 32'd9);
        tick();
        check_fe("rd3_n2", 1'b1, 32'h40, 32'd10);
        tick();
        check_fe("rd3_n3", 1'b1, 32'h40, 32'd10);
        tick();
        check_fe("rd3_n4", 1'b1, 32'h40, 32'd10);

        // One-cycle reset with live pipeline state
        reset = 1'b1;
        stall = 1'b0;
        check_addr("mrst_addr", 32'h0);
        tick();  // restart cycle 0
        reset = 1'b0;
        check_fe("mr0", 1'b0, 32'h0, 32'd0);
        check_addr("mr0_addr", 32'h0);
        tick();
        check_fe("mr1", 1'b0, 32'h0, 32'd0);
        tick();
        check_fe("mr2", 1'b1, 32'h0, 32'd1);
        tick();
        check_fe("mr3", 1'b1, 32'h4, 32'd2);
        tick();
        check_fe("mr4", 1'b1, 32'h8, 32'd3);

        check("skid_overflow", ovf_cnt, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
